// File: rtl/bypass_data_network.sv
// RR->EX operand bypass mux: latches per-operand selects and pipelines int/mem results one stage.
// Optional define BYPASS_MEM_WB_PATH_EN keeps the mem WB result registers and honours stage 3.
module bypass_data_network #(
    parameter int unsigned INT_LANES  = 2,
    parameter int unsigned MEM_LANES  = 1,
    parameter int unsigned OPERANDS   = 6,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic                            clear,
    input  logic [OPERANDS-1:0]             sel_valid,
    input  logic [OPERANDS*2-1:0]           sel_stg,
    input  logic [OPERANDS*2-1:0]           sel_lane,
    input  logic [INT_LANES*DATA_WIDTH-1:0] int_ex_data,
    input  logic [MEM_LANES*DATA_WIDTH-1:0] mem_ma_data,
    input  logic [OPERANDS*DATA_WIDTH-1:0]  rf_data,
    output logic [OPERANDS*DATA_WIDTH-1:0]  operand
);

    typedef enum logic [1:0] {
        STG_INT_EX = 2'd0,
        STG_INT_WB = 2'd1,
        STG_MEM_MA = 2'd2,
        STG_MEM_WB = 2'd3
    } stg_t;

    logic [OPERANDS-1:0]   sel_v_q;
    stg_t                  sel_stg_q  [OPERANDS];
    logic [1:0]            sel_lane_q [OPERANDS];
    logic [DATA_WIDTH-1:0] int_wb_q   [INT_LANES];
`ifdef BYPASS_MEM_WB_PATH_EN
    logic [DATA_WIDTH-1:0] mem_wb_q   [MEM_LANES];
`endif

    // rst and clear share the same reset image; stall only gates the load
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sel_v_q <= '0;
            for (int unsigned k = 0; k < OPERANDS; k++) begin
                sel_stg_q[k]  <= STG_INT_EX;
                sel_lane_q[k] <= '0;
            end
            for (int unsigned i = 0; i < INT_LANES; i++) int_wb_q[i] <= '0;
`ifdef BYPASS_MEM_WB_PATH_EN
            for (int unsigned j = 0; j < MEM_LANES; j++) mem_wb_q[j] <= '0;
`endif
        end else if (!stall) begin
            sel_v_q <= sel_valid;
            for (int unsigned k = 0; k < OPERANDS; k++) begin
                sel_stg_q[k]  <= stg_t'(sel_stg[2*k +: 2]);
                sel_lane_q[k] <= sel_lane[2*k +: 2];
            end
            for (int unsigned i = 0; i < INT_LANES; i++)
                int_wb_q[i] <= int_ex_data[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef BYPASS_MEM_WB_PATH_EN
            for (int unsigned j = 0; j < MEM_LANES; j++)
                mem_wb_q[j] <= mem_ma_data[j*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
    end

    // Lane matching by loop: an out-of-range lane never matches, so rf_data stays selected
    always_comb begin
        operand = rf_data;
        for (int unsigned k = 0; k < OPERANDS; k++) begin
            if (sel_v_q[k]) begin
                case (sel_stg_q[k])
                    STG_INT_EX: begin
                        for (int unsigned l = 0; l < INT_LANES; l++)
                            if (32'(sel_lane_q[k]) == l)
                                operand[k*DATA_WIDTH +: DATA_WIDTH] = int_ex_data[l*DATA_WIDTH +: DATA_WIDTH];
                    end
                    STG_INT_WB: begin
                        for (int unsigned l = 0; l < INT_LANES; l++)
                            if (32'(sel_lane_q[k]) == l)
                                operand[k*DATA_WIDTH +: DATA_WIDTH] = int_wb_q[l];
                    end
                    STG_MEM_MA: begin
                        for (int unsigned l = 0; l < MEM_LANES; l++)
                            if (32'(sel_lane_q[k]) == l)
                                operand[k*DATA_WIDTH +: DATA_WIDTH] = mem_ma_data[l*DATA_WIDTH +: DATA_WIDTH];
                    end
`ifdef BYPASS_MEM_WB_PATH_EN
                    STG_MEM_WB: begin
                        for (int unsigned l = 0; l < MEM_LANES; l++)
                            if (32'(sel_lane_q[k]) == l)
                                operand[k*DATA_WIDTH +: DATA_WIDTH] = mem_wb_q[l];
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bypass_data_network.sv
// Table-driven bench for bypass_data_network; each row is one cycle of stimulus plus one expected operand.
module tb_bypass_data_network;

    localparam int DW = 32;
    localparam int NOP = 6;

`ifdef BYPASS_MEM_WB_PATH_EN
    localparam logic [31:0] MWB_EXP = 32'h22;
`else
    localparam logic [31:0] MWB_EXP = 32'h104;
`endif

    logic                clk = 1'b0;
    logic                rst, stall, clear;
    logic [NOP-1:0]      sel_valid;
    logic [NOP*2-1:0]    sel_stg, sel_lane;
    logic [2*DW-1:0]     int_ex_data;
    logic [DW-1:0]       mem_ma_data;
    logic [NOP*DW-1:0]   rf_data;
    logic [NOP*DW-1:0]   operand;

    bypass_data_network #(
        .INT_LANES(2), .MEM_LANES(1), .OPERANDS(NOP), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .clear(clear),
        .sel_valid(sel_valid), .sel_stg(sel_stg), .sel_lane(sel_lane),
        .int_ex_data(int_ex_data), .mem_ma_data(mem_ma_data),
        .rf_data(rf_data), .operand(operand)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, clear;
        int          sel_op;
        logic [1:0]  stg, lane;
        logic [31:0] iex0, iex1, mma;
        int          chk_op;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          op_q[$];
    int          n_vec = 0;
    int          n_miss = 0;

    function automatic vec_t v(logic r, logic s, logic c, int op, logic [1:0] stg, logic [1:0] lane,
                               logic [31:0] i0, logic [31:0] i1, logic [31:0] m,
                               int chk, logic [31:0] e, string nm);
        vec_t t;
        t.rst = r; t.stall = s; t.clear = c; t.sel_op = op; t.stg = stg; t.lane = lane;
        t.iex0 = i0; t.iex1 = i1; t.mma = m; t.chk_op = chk; t.exp = e; t.name = nm;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        logic [31:0] got, e;
        int          k;
        @(negedge clk);
        rst = t.rst; stall = t.stall; clear = t.clear;
        sel_valid = '0; sel_stg = '0; sel_lane = '0;
        if (t.sel_op >= 0) begin
            sel_valid[t.sel_op]     = 1'b1;
            sel_stg[2*t.sel_op +: 2]  = t.stg;
            sel_lane[2*t.sel_op +: 2] = t.lane;
        end
        int_ex_data = {t.iex1, t.iex0};
        mem_ma_data = t.mma;
        exp_q.push_back(t.exp);
        op_q.push_back(t.chk_op);
        #2;
        e   = exp_q.pop_front();
        k   = op_q.pop_front();
        got = operand[k*DW +: DW];
        n_vec++;
        if (got !== e) begin
            n_miss++;
            $display("FAIL %s: operand[%0d] got %h expected %h", t.name, k, got, e);
        end
    endtask

    initial begin
        for (int k = 0; k < NOP; k++) rf_data[k*DW +: DW] = 32'h100 + k;
        rst = 1'b1; stall = 1'b0; clear = 1'b0;
        sel_valid = '0; sel_stg = '0; sel_lane = '0;
        int_ex_data = '0; mem_ma_data = '0;
        repeat (2) @(posedge clk);

        // main function: selects in row i steer the operand of row i+1
        vecs.push_back(v(0,0,0,-1,0,0, 0,0,0,             0,32'h100,"reset_rf"));
        vecs.push_back(v(0,0,0, 0,0,1, 0,0,0,             3,32'h103,"rf_op3"));
        vecs.push_back(v(0,0,0, 2,1,0, 32'h11,32'hDEADBEEF,0, 0,32'hDEADBEEF,"int_ex_lane1"));
        vecs.push_back(v(0,0,0,-1,0,0, 32'h99,32'h55,0,   2,32'h11,"int_wb_lane0"));
        vecs.push_back(v(0,0,0, 4,3,0, 0,0,32'h22,        0,32'h100,"sel_expired"));
        vecs.push_back(v(0,0,0,-1,0,0, 0,0,32'h33,        4,MWB_EXP,"mem_wb_lane0"));
        vecs.push_back(v(0,0,0, 5,2,0, 0,0,32'h44,        1,32'h101,"rf_op1"));
        vecs.push_back(v(0,0,0,-1,0,0, 0,0,32'h66,        5,32'h66,"mem_ma_lane0"));
        vecs.push_back(v(0,0,0, 3,2,2, 0,0,32'h77,        5,32'h105,"mem_ma_expired"));
        vecs.push_back(v(0,0,0,-1,0,0, 0,0,32'h78,        3,32'h103,"mem_lane_oob"));
        vecs.push_back(v(0,0,0, 1,0,3, 32'hAA,32'hBB,0,   3,32'h103,"rf_op3_b"));
        vecs.push_back(v(0,0,0,-1,0,0, 32'hCC,32'hDD,0,   1,32'h101,"int_lane_oob"));
        vecs.push_back(v(0,0,0, 5,1,1, 0,32'hE1,0,        0,32'h100,"rf_op0"));
        vecs.push_back(v(0,0,0, 4,0,0, 0,32'hE2,0,        5,32'hE1,"int_wb_lane1"));
        vecs.push_back(v(0,0,0,-1,0,0, 32'h7777,0,0,      4,32'h7777,"int_ex_lane0"));

        // stall: select and int_wb hold while int_ex_data changes
        vecs.push_back(v(0,0,0, 1,1,0, 32'hC0FFEE,0,0,    1,32'h101,"pre_stall"));
        for (int i = 1; i <= 3; i++)
            vecs.push_back(v(0,1,0,-1,0,0, i,0,0,         1,32'hC0FFEE,"stall_hold"));
        vecs.push_back(v(0,0,0,-1,0,0, 32'h4,0,0,         1,32'hC0FFEE,"stall_release"));
        vecs.push_back(v(0,0,0,-1,0,0, 32'h5,0,0,         1,32'h101,"post_stall"));

        // clear beats stall
        vecs.push_back(v(0,0,0, 1,1,0, 32'h5A5A,0,0,      1,32'h101,"pre_clear"));
        vecs.push_back(v(0,1,1, 1,1,0, 32'h77,0,0,        1,32'h5A5A,"clear_cycle"));
        vecs.push_back(v(0,0,0,-1,0,0, 32'h88,0,0,        1,32'h101,"after_clear"));

        // rst during stall
        vecs.push_back(v(0,0,0, 0,1,1, 0,32'hBB,0,        0,32'h100,"pre_rst"));
        vecs.push_back(v(1,1,0,-1,0,0, 0,32'hCC,0,        0,32'hBB,"rst_cycle"));
        vecs.push_back(v(0,1,0,-1,0,0, 0,32'hCC,0,        0,32'h100,"after_rst"));
        for (int k = 0; k < NOP; k++)
            vecs.push_back(v(0,0,0,-1,0,0, 32'h1234,32'h5678,32'h9ABC, k,32'h100 + k,"all_rf"));

        foreach (vecs[i]) apply(vecs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
